jtcontra_rom_slot: RTL and testbench

SDRAM-side responder for the graphics ROM request interface: accepts rom_cs/rom_addr from a 007121 graphics block and returns rom_data with rom_ok. It keeps a 2-entry word cache, issues single-word reads to the shared SDRAM controller and holds rom_ok while the requested word is valid. One instance sits between each graphics block and the SDRAM arbiter.

---
 rtl/jtcontra_pkg.sv | 12 +
 rtl/jtcontra_rom_cache.sv | 55 +++++
 rtl/jtcontra_rom_slot.sv | 128 ++++++++++++
 tb/tb_jtcontra_rom_slot.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcontra_pkg.sv
// Shared definitions for the contra ROM slot: FSM states and SDRAM word-address width.
package jtcontra_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/jtcontra_rom_cache.sv
// Two-entry word cache for a ROM slot: tag/data store, hit lookup, fill port,
// flush and round-robin replacement pointer.
module jtcontra_rom_cache #(
  parameter int AW = 18
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          lookup_cs,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [15:0]   hit_data,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_tag,
  input  logic [15:0]   fill_data
);

  logic [1:0]    valid;
  logic [AW-1:0] tag  [2];
  logic [15:0]   data [2];
  logic          ptr;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (lookup_cs && valid[i] && tag[i] == lookup_addr) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

  // A fill coinciding with flush keeps its own entry: the later per-bit
  // assignment overrides the whole-vector clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      ptr   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (flush) valid <= '0;
      if (fill_en) begin
        valid[ptr] <= 1'b1;
        tag[ptr]   <= fill_tag;
        data[ptr]  <= fill_data;
        ptr        <= ~ptr;
      end
    end
  end

endmodule

// File: rtl/jtcontra_rom_slot.sv
// SDRAM-side responder for a 007121 graphics ROM port: 2-entry word cache in
// front of single-word SDRAM reads, with registered rom_ok/rom_data return.
module jtcontra_rom_slot
  import jtcontra_pkg::*;
#(
  parameter int                  AW     = 18,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0,
  parameter bit                  LATCH  = 1'b1
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                downloading,
  input  logic                flush,
  input  logic                slot_cs,
  input  logic [AW-1:0]       slot_addr,
  output logic                slot_ok,
  output logic [15:0]         slot_dout,
  output logic                sdram_rd,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_dst,
  input  logic [15:0]         sdram_data
);

  state_t              state, state_nx;
  logic [AW-1:0]       req_addr, req_addr_nx;
  logic                rd_nx;
  logic [SDRAM_AW-1:0] addr_nx;
  logic [SDRAM_AW-1:0] addr_ext;
  logic                ok_q, ok_nx;
  logic [15:0]         dout_q, dout_nx;
  logic                hit;
  logic [15:0]         hit_data;
  logic                take;
  logic                fill_en;
  logic                ret_now;

  jtcontra_rom_cache #(
    .AW (AW)
  ) u_cache (
    .rst         (rst),
    .clk         (clk),
    .flush       (flush),
    .lookup_cs   (slot_cs),
    .lookup_addr (slot_addr),
    .hit         (hit),
    .hit_data    (hit_data),
    .fill_en     (fill_en),
    .fill_tag    (req_addr),
    .fill_data   (sdram_data)
  );

  assign addr_ext = SDRAM_AW'(slot_addr);

  always_comb begin
    // ack and dst together while in REQ behave as ack followed by dst
    take     = sdram_dst && (state == ST_WAIT || (state == ST_REQ && sdram_ack));
    fill_en  = take && !downloading;
    ret_now  = take && slot_cs && !flush && !downloading && slot_addr == req_addr;

    state_nx    = state;
    rd_nx       = sdram_rd;
    addr_nx     = sdram_addr;
    req_addr_nx = req_addr;
    case (state)
      ST_IDLE: begin
        if (slot_cs && !hit && !downloading) begin
          req_addr_nx = slot_addr;
          addr_nx     = addr_ext + OFFSET;
          rd_nx       = 1'b1;
          state_nx    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          rd_nx    = 1'b0;
          state_nx = sdram_dst ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_dst) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    ok_nx   = 1'b0;
    dout_nx = dout_q;
    if (flush || downloading || !slot_cs) begin
      ok_nx = 1'b0;
    end else if (hit) begin
      ok_nx   = 1'b1;
      dout_nx = hit_data;
    end else if (ret_now) begin
      ok_nx   = 1'b1;
      dout_nx = sdram_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
      req_addr   <= '0;
      ok_q       <= 1'b0;
      dout_q     <= '0;
    end else begin
      state      <= state_nx;
      sdram_rd   <= rd_nx;
      sdram_addr <= addr_nx;
      req_addr   <= req_addr_nx;
      ok_q       <= ok_nx;
      dout_q     <= dout_nx;
    end
  end

  generate
    if (LATCH) begin : g_latched
      assign slot_ok   = ok_q;
      assign slot_dout = dout_q;
    end else begin : g_bypass
      // Returned word is visible during the strobe cycle itself
      assign slot_ok   = ok_q | ret_now;
      assign slot_dout = ret_now ? sdram_data : dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_jtcontra_rom_slot.sv
// Bench for jtcontra_rom_slot: directed scenarios plus a randomized run
// against a transaction-level model (FIFO cache, single outstanding read).
module tb_jtcontra_rom_slot;

  localparam logic [21:0] OFS = 22'h10000;

  logic        rst, clk, downloading, flush, slot_cs;
  logic [17:0] slot_addr;
  logic        slot_ok, sdram_rd, sdram_ack, sdram_dst;
  logic [15:0] slot_dout, sdram_data;
  logic [21:0] sdram_addr;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        m_ok, m_rd;
  logic [15:0] m_dout;
  logic [21:0] m_addr;
  logic [17:0] c_tag[$];
  logic [15:0] c_dat[$];
  bit          pend, acked;
  logic [17:0] pend_addr;

  jtcontra_rom_slot #(
    .AW     (18),
    .OFFSET (OFS),
    .LATCH  (1'b1)
  ) dut (
    .rst         (rst),
    .clk         (clk),
    .downloading (downloading),
    .flush       (flush),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_rd    (sdram_rd),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .sdram_dst   (sdram_dst),
    .sdram_data  (sdram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    c_tag.delete();
    c_dat.delete();
    pend   = 0;
    acked  = 0;
    m_ok   = 1'b0;
    m_rd   = 1'b0;
    m_dout = '0;
    m_addr = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit          hit = 0;
    bit          fill;
    logic [15:0] hd = '0;
    for (int i = 0; i < c_tag.size(); i++)
      if (slot_cs && c_tag[i] == slot_addr) begin hit = 1; hd = c_dat[i]; end
    fill = pend && sdram_dst && (acked || sdram_ack);
    if (flush || downloading || !slot_cs) m_ok = 1'b0;
    else if (hit) begin m_ok = 1'b1; m_dout = hd; end
    else if (fill && slot_addr == pend_addr) begin m_ok = 1'b1; m_dout = sdram_data; end
    else m_ok = 1'b0;
    if (flush) begin c_tag.delete(); c_dat.delete(); end
    if (fill && !downloading) begin
      if (c_tag.size() == 2) begin void'(c_tag.pop_front()); void'(c_dat.pop_front()); end
      c_tag.push_back(pend_addr);
      c_dat.push_back(sdram_data);
    end
    if (fill) pend = 0;
    else if (pend && sdram_ack) acked = 1;
    else if (!pend && slot_cs && !hit && !downloading) begin
      pend      = 1;
      acked     = 0;
      pend_addr = slot_addr;
      m_addr    = {4'b0, slot_addr} + OFS;
    end
    m_rd = pend && !acked;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [15:0] d);
    sdram_ack = 1'b1;
    tick();
    sdram_ack  = 1'b0;
    sdram_dst  = 1'b1;
    sdram_data = d;
    tick();
    sdram_dst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total += 4;
    if (slot_ok !== 1'b0) begin bad++; $display("FAIL reset_ok got=%b want=0", slot_ok); end
    if (slot_dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0000", slot_dout); end
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b want=0", sdram_rd); end
    if (sdram_addr !== 22'h0) begin bad++; $display("FAIL reset_addr got=%h want=000000", sdram_addr); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_cold_miss();
    slot_cs = 1'b1; slot_addr = 18'h00123;
    tick();
    total += 2;
    if (sdram_rd !== 1'b1) begin bad++; $display("FAIL cold_rd got=%b want=1", sdram_rd); end
    if (sdram_addr !== 22'h10123) begin bad++; $display("FAIL cold_addr got=%h want=010123", sdram_addr); end
    tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    total++;
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL cold_rd_drop got=%b want=0", sdram_rd); end
    tick();
    sdram_dst = 1'b1; sdram_data = 16'hBEEF; tick(); sdram_dst = 1'b0;
    total += 2;
    if (slot_ok !== 1'b1) begin bad++; $display("FAIL cold_ok got=%b want=1", slot_ok); end
    if (slot_dout !== 16'hBEEF) begin bad++; $display("FAIL cold_dout got=%h want=beef", slot_dout); end
    tick();
    total += 2;
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL cold_no_rerd got=%b want=0", sdram_rd); end
    if (slot_ok !== 1'b1) begin bad++; $display("FAIL cold_hold_ok got=%b want=1", slot_ok); end
  endtask

  task automatic test_hit();
    logic [17:0] a;
    logic [15:0] w;
    slot_addr = 18'h00124; tick(); serve(16'h1124);
    for (int r = 0; r < 4; r++) begin
      a = (r % 2 == 0) ? 18'h00123 : 18'h00124;
      w = (r % 2 == 0) ? 16'hBEEF : 16'h1124;
      slot_addr = a;
      tick();
      for (int k = 0; k < 3; k++) begin
        tick();
        total += 3;
        if (slot_ok !== 1'b1) begin bad++; $display("FAIL hit_ok a=%h got=%b want=1", a, slot_ok); end
        if (slot_dout !== w) begin bad++; $display("FAIL hit_dout a=%h got=%h want=%h", a, slot_dout, w); end
        if (sdram_rd !== 1'b0) begin bad++; $display("FAIL hit_rd a=%h got=%b want=0", a, sdram_rd); end
      end
    end
    slot_addr = 18'h00125; tick(); serve(16'h1125);
    total++;
    if (slot_dout !== 16'h1125) begin bad++; $display("FAIL third_dout got=%h want=1125", slot_dout); end
    slot_addr = 18'h00124; tick(); tick();
    total += 2;
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL evict_keep_rd got=%b want=0", sdram_rd); end
    if (slot_dout !== 16'h1124) begin bad++; $display("FAIL evict_keep_dout got=%h want=1124", slot_dout); end
    slot_addr = 18'h00123; tick();
    total++;
    if (sdram_rd !== 1'b1) begin bad++; $display("FAIL evict_miss_rd got=%b want=1", sdram_rd); end
    serve(16'h1123);
  endtask

  task automatic test_addr_change();
    slot_addr = 18'h00200; tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    slot_addr = 18'h00300; tick();
    sdram_dst = 1'b1; sdram_data = 16'h2200; tick(); sdram_dst = 1'b0;
    total += 2;
    if (slot_ok !== 1'b0) begin bad++; $display("FAIL chg_ok got=%b want=0", slot_ok); end
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL chg_rd_fill got=%b want=0", sdram_rd); end
    tick();
    total += 2;
    if (sdram_rd !== 1'b1) begin bad++; $display("FAIL chg_rd2 got=%b want=1", sdram_rd); end
    if (sdram_addr !== 22'h10300) begin bad++; $display("FAIL chg_addr2 got=%h want=010300", sdram_addr); end
    serve(16'h3300);
    total++;
    if (slot_dout !== 16'h3300) begin bad++; $display("FAIL chg_dout2 got=%h want=3300", slot_dout); end
    slot_addr = 18'h00200; tick(); tick();
    total += 2;
    if (slot_ok !== 1'b1) begin bad++; $display("FAIL chg_cached_ok got=%b want=1", slot_ok); end
    if (slot_dout !== 16'h2200) begin bad++; $display("FAIL chg_cached_dout got=%h want=2200", slot_dout); end
  endtask

  task automatic test_flush();
    slot_addr = 18'h00123; tick(); serve(16'hA123); tick();
    total++;
    if (slot_dout !== 16'hA123) begin bad++; $display("FAIL fl_pre_dout got=%h want=a123", slot_dout); end
    flush = 1'b1; tick(); flush = 1'b0;
    total++;
    if (slot_ok !== 1'b0) begin bad++; $display("FAIL fl_ok got=%b want=0", slot_ok); end
    tick();
    total += 2;
    if (sdram_rd !== 1'b1) begin bad++; $display("FAIL fl_rd got=%b want=1", sdram_rd); end
    if (sdram_addr !== 22'h10123) begin bad++; $display("FAIL fl_addr got=%h want=010123", sdram_addr); end
    serve(16'hB123);
    total++;
    if (slot_dout !== 16'hB123) begin bad++; $display("FAIL fl_refill got=%h want=b123", slot_dout); end
  endtask

  task automatic test_downloading();
    downloading = 1'b1; slot_addr = 18'h003AB;
    for (int k = 0; k < 5; k++) begin
      tick();
      total += 2;
      if (sdram_rd !== 1'b0) begin bad++; $display("FAIL dl_rd got=%b want=0", sdram_rd); end
      if (slot_ok !== 1'b0) begin bad++; $display("FAIL dl_ok got=%b want=0", slot_ok); end
    end
    downloading = 1'b0; tick();
    total += 2;
    if (sdram_rd !== 1'b1) begin bad++; $display("FAIL dl_rel_rd got=%b want=1", sdram_rd); end
    if (sdram_addr !== 22'h103AB) begin bad++; $display("FAIL dl_rel_addr got=%h want=0103ab", sdram_addr); end
    serve(16'h5A5A);
    total += 2;
    if (slot_ok !== 1'b1) begin bad++; $display("FAIL dl_fill_ok got=%b want=1", slot_ok); end
    if (slot_dout !== 16'h5A5A) begin bad++; $display("FAIL dl_fill_dout got=%h want=5a5a", slot_dout); end
  endtask

  task automatic test_ack_dst_same();
    slot_addr = 18'h00456; tick();
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 16'h4567; tick();
    sdram_ack = 1'b0; sdram_dst = 1'b0;
    total += 3;
    if (slot_ok !== 1'b1) begin bad++; $display("FAIL same_ok got=%b want=1", slot_ok); end
    if (slot_dout !== 16'h4567) begin bad++; $display("FAIL same_dout got=%h want=4567", slot_dout); end
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL same_rd got=%b want=0", sdram_rd); end
    tick();
    total++;
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL same_no_rerd got=%b want=0", sdram_rd); end
  endtask

  task automatic test_async_reset();
    slot_addr = 18'h00777; tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    rst = 1'b1;
    #2;
    total += 4;
    if (slot_ok !== 1'b0) begin bad++; $display("FAIL ar_ok got=%b want=0", slot_ok); end
    if (slot_dout !== 16'h0) begin bad++; $display("FAIL ar_dout got=%h want=0000", slot_dout); end
    if (sdram_rd !== 1'b0) begin bad++; $display("FAIL ar_rd got=%b want=0", sdram_rd); end
    if (sdram_addr !== 22'h0) begin bad++; $display("FAIL ar_addr got=%h want=000000", sdram_addr); end
    rst = 1'b0;
    model_reset();
    slot_cs = 1'b0; sdram_dst = 1'b1; sdram_data = 16'hDEAD; tick(); sdram_dst = 1'b0;
    total += 2;
    if (slot_ok !== 1'b0) begin bad++; $display("FAIL ar_orphan_ok got=%b want=0", slot_ok); end
    if (slot_dout !== 16'h0) begin bad++; $display("FAIL ar_orphan_dout got=%h want=0000", slot_dout); end
    slot_cs = 1'b1; tick();
    total += 2;
    if (sdram_rd !== 1'b1) begin bad++; $display("FAIL ar_fresh_rd got=%b want=1", sdram_rd); end
    if (sdram_addr !== 22'h10777) begin bad++; $display("FAIL ar_fresh_addr got=%h want=010777", sdram_addr); end
    serve(16'h7777);
    total++;
    if (slot_dout !== 16'h7777) begin bad++; $display("FAIL ar_fresh_dout got=%h want=7777", slot_dout); end
  endtask

  task automatic test_random();
    logic [17:0] pool[5];
    pool[0] = 18'h00010; pool[1] = 18'h00011; pool[2] = 18'h3FFFF;
    pool[3] = 18'h20000; pool[4] = 18'h00123;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(3) == 0) slot_addr = pool[$urandom_range(4)];
      slot_cs = ($urandom_range(9) != 0);
      flush   = ($urandom_range(24) == 0);
      if ($urandom_range(39) == 0) downloading = ~downloading;
      sdram_ack  = m_rd && ($urandom_range(2) == 0);
      sdram_dst  = (pend && (acked || sdram_ack)) ? ($urandom_range(2) == 0)
                                                  : ($urandom_range(15) == 0);
      sdram_data = 16'($urandom);
      tick();
      total += 4;
      if (slot_ok !== m_ok) begin bad++; $display("FAIL rnd_ok n=%0d got=%b want=%b", n, slot_ok, m_ok); end
      if (slot_dout !== m_dout) begin bad++; $display("FAIL rnd_dout n=%0d got=%h want=%h", n, slot_dout, m_dout); end
      if (sdram_rd !== m_rd) begin bad++; $display("FAIL rnd_rd n=%0d got=%b want=%b", n, sdram_rd, m_rd); end
      if (sdram_addr !== m_addr) begin bad++; $display("FAIL rnd_addr n=%0d got=%h want=%h", n, sdram_addr, m_addr); end
    end
    flush = 1'b0; downloading = 1'b0; sdram_ack = 1'b0; sdram_dst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; flush = 1'b0; slot_cs = 1'b0;
    slot_addr = '0; sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
    model_reset();
    test_reset();
    test_cold_miss();
    test_hit();
    test_addr_change();
    test_flush();
    test_downloading();
    test_ack_dst_same();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
